// File: rtl/controlador_venda.sv
// Sequencing controller for the vending machine coin accumulator: product
// selection, price check, dispense timing, change/refund and inactivity timeout.
module controlador_venda #(
  parameter int         TIMEOUT_CYCLES  = 1000,
  parameter int         DISPENSE_CYCLES = 4,
  parameter logic [3:0] PRECO_A         = 4'd6,
  parameter logic [3:0] PRECO_B         = 4'd8,
  parameter logic [3:0] PRECO_C         = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] valorAcumulado,
  input  logic       moedaInserida,
  input  logic [1:0] selecao,
  input  logic       confirmar,
  input  logic       cancelar,
  output logic       limpar,
  output logic       bloqueioMoeda,
  output logic       liberar,
  output logic [1:0] produto,
  output logic [3:0] troco,
  output logic       trocoValido,
  output logic       saldoInsuf,
  output logic       erroExcesso,
  output logic [2:0] estado
);

  localparam logic [2:0] S_OCIOSO     = 3'd0;
  localparam logic [2:0] S_ACUMULANDO = 3'd1;
  localparam logic [2:0] S_VERIFICA   = 3'd2;
  localparam logic [2:0] S_LIBERA     = 3'd3;
  localparam logic [2:0] S_TROCO      = 3'd4;
  localparam logic [2:0] S_DEVOLVE    = 3'd5;
  localparam logic [2:0] S_LIMPA      = 3'd6;

  localparam logic [3:0] VALOR_EXCESSO = 4'hF;

  // One down-counter serves both the inactivity timeout and the dispense
  // duration, so it is sized for the larger of the two.
  localparam int TMAX = (TIMEOUT_CYCLES > DISPENSE_CYCLES) ? TIMEOUT_CYCLES : DISPENSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_RELOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] DISPENSE_RELOAD = TW'(DISPENSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ZERO      = '0;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    troco_q, troco_d;
  logic [1:0]    produto_q, produto_d;
  logic          saldo_q, saldo_d;
  logic          erro_q, erro_d;
  logic [3:0]    preco;

  // Price of the latched product.
  always_comb begin
    preco = PRECO_A;
    case (produto_q)
      2'b01:   preco = PRECO_A;
      2'b10:   preco = PRECO_B;
      2'b11:   preco = PRECO_C;
      default: preco = PRECO_A;
    endcase
  end

  // State and datapath registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OCIOSO;
      timer_q   <= '0;
      troco_q   <= '0;
      produto_q <= '0;
      saldo_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      troco_q   <= troco_d;
      produto_q <= produto_d;
      saldo_q   <= saldo_d;
      erro_q    <= erro_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    troco_d   = troco_q;
    produto_d = produto_q;
    saldo_d   = 1'b0;
    erro_d    = 1'b0;
    case (state_q)
      S_OCIOSO: begin
        if (moedaInserida) begin
          state_d = S_ACUMULANDO;
          timer_d = TIMEOUT_RELOAD;
        end
      end
      S_ACUMULANDO: begin
        timer_d = moedaInserida ? TIMEOUT_RELOAD : timer_q - 1'b1;
        if (valorAcumulado == VALOR_EXCESSO) begin
          erro_d  = 1'b1;
          state_d = S_LIMPA;
        end else if (cancelar) begin
          troco_d = valorAcumulado;
          state_d = S_DEVOLVE;
        end else if (timer_q == TIMER_ZERO && !moedaInserida) begin
          // A coin arriving on the last cycle keeps the session alive.
          troco_d = valorAcumulado;
          state_d = S_DEVOLVE;
        end else if (confirmar && selecao != 2'b00) begin
          produto_d = selecao;
          state_d   = S_VERIFICA;
        end
      end
      S_VERIFICA: begin
        if (valorAcumulado >= preco) begin
          troco_d = valorAcumulado - preco;
          timer_d = DISPENSE_RELOAD;
          state_d = S_LIBERA;
        end else begin
          // Back to accumulating with whatever time was left.
          saldo_d = 1'b1;
          state_d = S_ACUMULANDO;
        end
      end
      S_LIBERA: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == TIMER_ZERO) begin
          timer_d = TIMER_ZERO;
          state_d = (troco_q != 4'd0) ? S_TROCO : S_LIMPA;
        end
      end
      S_TROCO:   state_d = S_LIMPA;
      S_DEVOLVE: state_d = S_LIMPA;
      S_LIMPA:   state_d = S_OCIOSO;
      default:   state_d = S_LIMPA;
    endcase
  end

  // Moore outputs decoded from the state and registered pulses.
  always_comb begin
    limpar        = (state_q == S_LIMPA);
    liberar       = (state_q == S_LIBERA);
    trocoValido   = (state_q == S_TROCO) || (state_q == S_DEVOLVE);
    bloqueioMoeda = (state_q != S_OCIOSO) && (state_q != S_ACUMULANDO);
    produto       = produto_q;
    troco         = troco_q;
    saldoInsuf    = saldo_q;
    erroExcesso   = erro_q;
    estado        = state_q;
  end

endmodule

// File: tb/tb_controlador_venda.sv
// Directed testbench for controlador_venda (timeout shortened to 10 cycles).
module tb_controlador_venda;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valorAcumulado;
  logic       moedaInserida;
  logic [1:0] selecao;
  logic       confirmar;
  logic       cancelar;
  logic       limpar;
  logic       bloqueioMoeda;
  logic       liberar;
  logic [1:0] produto;
  logic [3:0] troco;
  logic       trocoValido;
  logic       saldoInsuf;
  logic       erroExcesso;
  logic [2:0] estado;

  int compared   = 0;
  int mismatched = 0;

  controlador_venda #(
    .TIMEOUT_CYCLES (10),
    .DISPENSE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valorAcumulado(valorAcumulado),
    .moedaInserida (moedaInserida),
    .selecao       (selecao),
    .confirmar     (confirmar),
    .cancelar      (cancelar),
    .limpar        (limpar),
    .bloqueioMoeda (bloqueioMoeda),
    .liberar       (liberar),
    .produto       (produto),
    .troco         (troco),
    .trocoValido   (trocoValido),
    .saldoInsuf    (saldoInsuf),
    .erroExcesso   (erroExcesso),
    .estado        (estado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until OCIOSO (bounded), tallying what the transaction produced.
  task automatic run_to_idle(output int lib, output int tv, output logic [3:0] tv_troco,
                             output int lim, output logic [1:0] prod, output bit reached);
    lib = 0; tv = 0; tv_troco = 4'd0; lim = 0; prod = 2'b00; reached = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (liberar) begin lib++; prod = produto; end
      if (trocoValido) begin tv++; tv_troco = troco; end
      if (limpar) lim++;
      if (estado == 3'd0) begin reached = 1'b1; break; end
    end
  endtask

  // Coin pulse into ACUMULANDO with the given credit.
  task automatic coin(input logic [3:0] v);
    valorAcumulado = v;
    moedaInserida  = 1'b1;
    tick();
    moedaInserida  = 1'b0;
  endtask

  task automatic confirm(input logic [1:0] s);
    selecao   = s;
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
  endtask

  task automatic test_reset();
    compared++;
    if ({limpar, bloqueioMoeda, liberar, produto, troco, trocoValido, saldoInsuf, erroExcesso, estado} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got estado=%0d lib=%b blq=%b lim=%b tv=%b troco=%0d, required all zero",
               estado, liberar, bloqueioMoeda, limpar, trocoValido, troco);
    end
    $display("txn reset: estado=%0d", estado);
  endtask

  task automatic test_compra_exata();
    int lib, tv, lim; logic [3:0] tt; logic [1:0] pr; bit ok;
    coin(4'd6);
    compared++;
    if (estado !== 3'd1) begin mismatched++; $display("FAIL exata_acum: estado=%0d required 1", estado); end
    confirm(2'b01);
    compared++;
    if (estado !== 3'd2 || bloqueioMoeda !== 1'b1) begin
      mismatched++; $display("FAIL exata_verifica: estado=%0d blq=%b required 2/1", estado, bloqueioMoeda);
    end
    run_to_idle(lib, tv, tt, lim, pr, ok);
    compared++;
    if (!ok || lib != 4 || pr !== 2'b01 || tv != 0 || lim != 1) begin
      mismatched++;
      $display("FAIL exata_dispense: ok=%0d lib=%0d prod=%b tv=%0d lim=%0d required 1/4/01/0/1", ok, lib, pr, tv, lim);
    end
    $display("txn compra_exata: lib=%0d prod=%b tv=%0d lim=%0d", lib, pr, tv, lim);
  endtask

  task automatic test_compra_troco();
    int lib, tv, lim; logic [3:0] tt; logic [1:0] pr; bit ok;
    coin(4'd8);
    confirm(2'b11);
    run_to_idle(lib, tv, tt, lim, pr, ok);
    compared++;
    if (!ok || lib != 4 || pr !== 2'b11 || tv != 1 || tt !== 4'd4 || lim != 1) begin
      mismatched++;
      $display("FAIL troco_dispense: ok=%0d lib=%0d prod=%b tv=%0d troco=%0d lim=%0d required 1/4/11/1/4/1",
               ok, lib, pr, tv, tt, lim);
    end
    $display("txn compra_troco: lib=%0d tv=%0d troco=%0d", lib, tv, tt);
  endtask

  task automatic test_saldo_insuf();
    int lib, tv, lim; logic [3:0] tt; logic [1:0] pr; bit ok;
    coin(4'd4);
    confirm(2'b10);
    tick();
    compared++;
    if (estado !== 3'd1 || saldoInsuf !== 1'b1) begin
      mismatched++; $display("FAIL saldo_pulse: estado=%0d saldo=%b required 1/1", estado, saldoInsuf);
    end
    tick();
    compared++;
    if (saldoInsuf !== 1'b0 || estado !== 3'd1) begin
      mismatched++; $display("FAIL saldo_width: saldo=%b estado=%0d required 0/1", saldoInsuf, estado);
    end
    valorAcumulado = 4'd8;
    confirm(2'b10);
    run_to_idle(lib, tv, tt, lim, pr, ok);
    compared++;
    if (!ok || lib != 4 || pr !== 2'b10 || tv != 0 || lim != 1) begin
      mismatched++;
      $display("FAIL saldo_retry: ok=%0d lib=%0d prod=%b tv=%0d lim=%0d required 1/4/10/0/1", ok, lib, pr, tv, lim);
    end
    $display("txn saldo_insuf: retry lib=%0d tv=%0d", lib, tv);
  endtask

  task automatic test_timeout();
    int lib, tv, lim; logic [3:0] tt; logic [1:0] pr; bit ok;
    coin(4'd3);
    repeat (9) tick();
    compared++;
    if (estado !== 3'd1 || trocoValido !== 1'b0) begin
      mismatched++; $display("FAIL timeout_early: estado=%0d tv=%b required 1/0", estado, trocoValido);
    end
    tick();
    compared++;
    if (estado !== 3'd5 || trocoValido !== 1'b1 || troco !== 4'd3 || bloqueioMoeda !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_refund: estado=%0d tv=%b troco=%0d blq=%b required 5/1/3/1", estado, trocoValido, troco, bloqueioMoeda);
    end
    run_to_idle(lib, tv, tt, lim, pr, ok);
    compared++;
    if (!ok || lim != 1 || tv != 0) begin
      mismatched++; $display("FAIL timeout_clear: ok=%0d lim=%0d tv=%0d required 1/1/0", ok, lim, tv);
    end
    $display("txn timeout: troco=3 lim=%0d", lim);
  endtask

  task automatic test_timeout_reload();
    int seen_tv = 0;
    coin(4'd3);
    repeat (9) begin tick(); if (trocoValido) seen_tv++; end
    // Timer is at zero here; a coin in this cycle must win.
    coin(4'd4);
    repeat (9) begin if (trocoValido) seen_tv++; tick(); end
    compared++;
    if (estado !== 3'd1 || seen_tv != 0 || trocoValido !== 1'b0) begin
      mismatched++; $display("FAIL reload_hold: estado=%0d tv_seen=%0d required 1/0", estado, seen_tv);
    end
    tick();
    compared++;
    if (estado !== 3'd5 || troco !== 4'd4) begin
      mismatched++; $display("FAIL reload_expire: estado=%0d troco=%0d required 5/4", estado, troco);
    end
    repeat (2) tick();
    $display("txn timeout_reload: expired with troco=%0d", troco);
  endtask

  task automatic test_excesso();
    coin(4'd7);
    valorAcumulado = 4'hF;
    tick();
    compared++;
    if (estado !== 3'd6 || erroExcesso !== 1'b1 || limpar !== 1'b1 || trocoValido !== 1'b0) begin
      mismatched++;
      $display("FAIL excesso_detect: estado=%0d erro=%b lim=%b tv=%b required 6/1/1/0", estado, erroExcesso, limpar, trocoValido);
    end
    valorAcumulado = 4'd0;
    tick();
    compared++;
    if (estado !== 3'd0 || erroExcesso !== 1'b0 || limpar !== 1'b0 || trocoValido !== 1'b0) begin
      mismatched++;
      $display("FAIL excesso_idle: estado=%0d erro=%b lim=%b tv=%b required 0/0/0/0", estado, erroExcesso, limpar, trocoValido);
    end
    $display("txn excesso: back to estado=%0d", estado);
  endtask

  task automatic test_cancelar();
    int lib, tv, lim; logic [3:0] tt; logic [1:0] pr; bit ok;
    coin(4'd5);
    selecao = 2'b01; confirmar = 1'b1; cancelar = 1'b1;
    tick();
    confirmar = 1'b0; cancelar = 1'b0;
    compared++;
    if (estado !== 3'd5 || trocoValido !== 1'b1 || troco !== 4'd5) begin
      mismatched++; $display("FAIL cancel_refund: estado=%0d tv=%b troco=%0d required 5/1/5", estado, trocoValido, troco);
    end
    run_to_idle(lib, tv, tt, lim, pr, ok);
    compared++;
    if (!ok || lib != 0 || lim != 1) begin
      mismatched++; $display("FAIL cancel_clear: ok=%0d lib=%0d lim=%0d required 1/0/1", ok, lib, lim);
    end
    $display("txn cancelar: troco=5 lim=%0d", lim);
  endtask

  task automatic test_ignorados();
    valorAcumulado = 4'd6;
    confirm(2'b01);
    compared++;
    if (estado !== 3'd0) begin mismatched++; $display("FAIL ignore_idle_confirm: estado=%0d required 0", estado); end
    coin(4'd6);
    confirm(2'b00);
    compared++;
    if (estado !== 3'd1) begin mismatched++; $display("FAIL ignore_nosel: estado=%0d required 1", estado); end
    cancelar = 1'b1; tick(); cancelar = 1'b0;
    repeat (2) tick();
    $display("txn ignorados: estado=%0d", estado);
  endtask

  task automatic test_reset_liberando();
    int seen_tv = 0;
    coin(4'd8);
    confirm(2'b11);
    tick();
    tick();
    compared++;
    if (liberar !== 1'b1) begin mismatched++; $display("FAIL rst_pre: lib=%b required 1", liberar); end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (liberar !== 1'b0 || estado !== 3'd0 || troco !== 4'd0) begin
      mismatched++; $display("FAIL rst_abort: lib=%b estado=%0d troco=%0d required 0/0/0", liberar, estado, troco);
    end
    tick();
    reset = 1'b0;
    repeat (8) begin tick(); if (trocoValido) seen_tv++; end
    compared++;
    if (seen_tv != 0 || estado !== 3'd0) begin
      mismatched++; $display("FAIL rst_no_change: tv_seen=%0d estado=%0d required 0/0", seen_tv, estado);
    end
    $display("txn reset_liberando: estado=%0d", estado);
  endtask

  initial begin
    reset = 1'b1;
    valorAcumulado = 4'd0; moedaInserida = 1'b0; selecao = 2'b00;
    confirmar = 1'b0; cancelar = 1'b0;
    repeat (2) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_compra_exata();
    test_compra_troco();
    test_saldo_insuf();
    test_timeout();
    test_timeout_reload();
    test_excesso();
    test_cancelar();
    test_ignorados();
    test_reset_liberando();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/controlador_venda.md
Name: controlador_venda

Overview:
- Sequencing controller for the coin accumulator in the vending machine datapath.
- Watches the accumulated credit (4-bit, units of R$0,25, 0..8 valid, 4'hF = overflow).
- Handles product selection, price check, dispense timing, change/refund output and inactivity timeout.
- Drives the accumulator's clear input (tempoLimite) and gates further coin acceptance while a transaction completes.

Parameters:
- TIMEOUT_CYCLES, 1000, inactivity cycles in ACUMULANDO before automatic refund.
- DISPENSE_CYCLES, 4, cycles liberar is held high.
- PRECO_A, 4'd6, price of product A in quarters (1,50).
- PRECO_B, 4'd8, price of product B (2,00).
- PRECO_C, 4'd4, price of product C (1,00).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- valorAcumulado  in  4  credit from accumulator, quarters; 4'hF = overflow
- moedaInserida  in  1  one-cycle pulse per accepted coin
- selecao  in  2  00 none, 01 A, 10 B, 11 C
- confirmar  in  1  purchase request pulse
- cancelar  in  1  refund request pulse
- limpar  out  1  to accumulator tempoLimite; clears credit
- bloqueioMoeda  out  1  coin acceptor must reject coins while high
- liberar  out  1  dispense motor enable
- produto  out  2  product being dispensed (valid while liberar)
- troco  out  4  change/refund amount in quarters (valid with trocoValido)
- trocoValido  out  1  one-cycle pulse
- saldoInsuf  out  1  one-cycle pulse, credit below price
- erroExcesso  out  1  one-cycle pulse, accumulator overflow seen
- estado  out  3  current state encoding, for debug/display

Behaviour:
- Reset (async): state OCIOSO. All outputs 0 except bloqueioMoeda=0. Internal registers troco, produto and timer = 0.
- All outputs registered/state-decoded (Moore); no combinational path from inputs to outputs.
- States and encodings: OCIOSO=0, ACUMULANDO=1, VERIFICA=2, LIBERA=3, TROCO=4, DEVOLVE=5, LIMPA=6. Unused codes go to LIMPA.
- OCIOSO: on moedaInserida, go to ACUMULANDO and load timer = TIMEOUT_CYCLES-1.
- ACUMULANDO: timer decrements each cycle and reloads on moedaInserida. Transition priority:
  - valorAcumulado==4'hF: erroExcesso pulse, go to LIMPA.
  - cancelar: go to DEVOLVE.
  - timer==0: go to DEVOLVE.
  - confirmar with selecao!=0: latch produto=selecao, go to VERIFICA.
  - confirmar with selecao==0 is ignored.
- VERIFICA (1 cycle): compare valorAcumulado against the price of produto using unsigned 4-bit arithmetic.
  - If credit >= price: troco <= credit - price, go to LIBERA.
  - Else: saldoInsuf pulse, return to ACUMULANDO. The timer is not reloaded.
- LIBERA: liberar=1 for exactly DISPENSE_CYCLES cycles, then go to TROCO if troco!=0, else to LIMPA.
- TROCO: trocoValido=1 for 1 cycle with troco held, then go to LIMPA.
- DEVOLVE: troco <= valorAcumulado, trocoValido=1 for 1 cycle, then go to LIMPA. A refund of 0 still pulses.
- LIMPA: limpar=1 for 1 cycle, then go to OCIOSO. The accumulator reads 0 one cycle later.
- bloqueioMoeda=1 in VERIFICA, LIBERA, TROCO, DEVOLVE and LIMPA.
- cancelar and confirmar are ignored outside ACUMULANDO.
- Simultaneous cancelar+confirmar in ACUMULANDO: cancelar wins.
- Simultaneous moedaInserida and timer==0: the coin wins and the timer reloads.
- Reset mid-dispense aborts immediately: liberar drops asynchronously and no change is issued.

Test Plan:
- Coin pulse with valor=6, selecao=01, confirmar -> VERIFICA, then liberar high exactly 4 cycles, produto=01, no trocoValido, limpar 1 cycle, back to OCIOSO.
- valor=8, selecao=11 (price 4), confirmar -> liberar 4 cycles, then trocoValido with troco=4, then limpar.
- valor=4, selecao=10 (price 8), confirmar -> saldoInsuf 1 cycle, back to ACUMULANDO. Later valor=8 + confirmar -> dispense with troco=0.
- valor=3, no activity for TIMEOUT_CYCLES (bench sets 10) -> trocoValido with troco=3, limpar. A coin at cycle 9 reloads the timer and no refund occurs.
- valor=4'hF in ACUMULANDO -> erroExcesso pulse, limpar, OCIOSO, no trocoValido. cancelar+confirmar together with valor=5 -> refund troco=5.
- Assert reset during LIBERA cycle 2 -> liberar=0, state OCIOSO, trocoValido never pulses.
